// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_sup_pkg
// Description : Shared definitions for the PLL supervisor. This package holds
//               the 3-bit supervisor state encoding, the default values of the
//               sequencing parameters, and a helper that sizes the counters.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_sup_pkg;

    // Supervisor state encoding
    localparam logic [2:0] c_ST_RESET     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_SETTLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAILED    = 3'd4;

    // Default sequencing parameters
    localparam int c_DEF_RST_CYCLES    = 16;
    localparam int c_DEF_LOCK_TIMEOUT  = 65535;
    localparam int c_DEF_SETTLE_CYCLES = 128;
    localparam int c_DEF_MAX_RETRIES   = 3;
    localparam int c_DEF_CNT_W         = 8;

    // Width needed to hold the values 0..n-1. Never returns less than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_supervisor_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Generic two-flop synchronizer with an asynchronous,
//               active-low clear. It is used for single-bit or
//               quasi-static CDC signals.
// Ports       : clk_in   - destination clock
//               rst_n_in - asynchronous clear, active-low
//               d        - asynchronous input
//               q        - synchronized output (two destination cycles later)
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor
// Description : Sequences the ECP5 PLL. The block pulses the PLL reset and
//               waits for lock, giving up after a timeout. It then qualifies
//               lock over a settle window and releases the domain reset
//               request. While running it watches for lock loss. A bounded
//               number of failed attempts leads to a sticky FAILED state.
// Ports       : clk_in    - 100 MHz reference clock
//               rst_n_in  - asynchronous active-low reset
//               pll_lock  - PLL LOCK output (asynchronous)
//               retry_req - single-cycle request to restart sequencing
//               pll_rst   - PLL RST, active-high
//               rst_out   - domain reset request, active-high
//               locked    - high only in RUN
//               failed    - high only in FAILED
//               retry_cnt - failed attempts since last RUN entry / retry_req
//               loss_cnt  - lock losses seen in RUN, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = c_DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = c_DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = c_DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = c_DEF_MAX_RETRIES,
    parameter int CNT_W         = c_DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             pll_lock,
    input  logic             retry_req,
    output logic             pll_rst,
    output logic             rst_out,
    output logic             locked,
    output logic             failed,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int c_PW = cnt_width(RST_CYCLES);
    localparam int c_TW = cnt_width(LOCK_TIMEOUT);
    localparam int c_SW = cnt_width(SETTLE_CYCLES);

    localparam logic [c_PW-1:0]  c_PHASE_LAST  = c_PW'(RST_CYCLES - 1);
    localparam logic [c_TW-1:0]  c_TMO_LAST    = c_TW'(LOCK_TIMEOUT - 1);
    localparam logic [c_SW-1:0]  c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MAX_RETRY   = CNT_W'(MAX_RETRIES);

    logic             w_lock_s;

    logic [2:0]       r_state;
    logic [c_PW-1:0]  r_phase;
    logic [c_TW-1:0]  r_tmo;
    logic [c_SW-1:0]  r_settle;
    logic [CNT_W-1:0] r_retry;
    logic [CNT_W-1:0] r_loss;
    logic             r_pll_rst;
    logic             r_rst_out;
    logic             r_locked;
    logic             r_failed;

    logic [2:0]       w_state_nxt;
    logic [c_PW-1:0]  w_phase_nxt;
    logic [c_TW-1:0]  w_tmo_nxt;
    logic [c_SW-1:0]  w_settle_nxt;
    logic [CNT_W-1:0] w_retry_nxt;
    logic [CNT_W-1:0] w_loss_nxt;
    logic [CNT_W-1:0] w_retry_inc;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d        (pll_lock),
        .q        (w_lock_s)
    );

    assign w_retry_inc = r_retry + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_tmo_nxt    = r_tmo;
        w_settle_nxt = r_settle;
        w_retry_nxt  = r_retry;
        w_loss_nxt   = r_loss;

        if (retry_req) begin
            // A restart request overrides everything. This includes a lock
            // loss in the same cycle, so that loss is not counted.
            w_state_nxt = c_ST_RESET;
            w_phase_nxt = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                c_ST_RESET: begin
                    if (r_phase == c_PHASE_LAST) begin
                        w_state_nxt = c_ST_WAIT_LOCK;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        // The cycle that first sees lock counts as the
                        // first qualified cycle of the settle window.
                        w_state_nxt  = c_ST_SETTLE;
                        w_settle_nxt = c_SW'(1);
                    end else if (r_tmo == c_TMO_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_phase_nxt = '0;
                        w_state_nxt = (w_retry_inc == c_MAX_RETRY) ? c_ST_FAILED
                                                                   : c_ST_RESET;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
                c_ST_SETTLE: begin
                    if (!w_lock_s) begin
                        // A dropout during settle is not a failed attempt.
                        w_state_nxt = c_ST_WAIT_LOCK;
                        w_tmo_nxt   = '0;
                    end else if (r_settle >= c_SETTLE_LAST) begin
                        w_state_nxt = c_ST_RUN;
                        w_retry_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = c_ST_RESET;
                        w_phase_nxt = '0;
                        if (r_loss != '1) begin
                            w_loss_nxt = r_loss + 1'b1;
                        end
                    end
                end
                c_ST_FAILED: begin
                    w_state_nxt = c_ST_FAILED;
                end
                default: begin
                    w_state_nxt = c_ST_RESET;
                    w_phase_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state. As a result they switch on
    // the same edge as the state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= c_ST_RESET;
            r_phase   <= '0;
            r_tmo     <= '0;
            r_settle  <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_rst_out <= 1'b1;
            r_locked  <= 1'b0;
            r_failed  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_tmo     <= w_tmo_nxt;
            r_settle  <= w_settle_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_pll_rst <= (w_state_nxt == c_ST_RESET) || (w_state_nxt == c_ST_FAILED);
            r_rst_out <= (w_state_nxt != c_ST_RUN);
            r_locked  <= (w_state_nxt == c_ST_RUN);
            r_failed  <= (w_state_nxt == c_ST_FAILED);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign rst_out   = r_rst_out;
    assign locked    = r_locked;
    assign failed    = r_failed;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;

endmodule
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_supervisor
// Description : Self-checking bench for pll_supervisor. It combines a
//               directed vector table, hand-written corner sequences, and a
//               randomized lock/retry run. All of these are compared every
//               cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_supervisor;

    localparam int P_RST = 4;
    localparam int P_LT  = 20;
    localparam int P_SET = 8;
    localparam int P_MR  = 3;
    localparam int P_CW  = 8;

    logic            clk_in    = 1'b0;
    logic            rst_n_in  = 1'b0;
    logic            pll_lock  = 1'b0;
    logic            retry_req = 1'b0;
    logic            pll_rst;
    logic            rst_out;
    logic            locked;
    logic            failed;
    logic [P_CW-1:0] retry_cnt;
    logic [P_CW-1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_supervisor #(
        .RST_CYCLES    (P_RST),
        .LOCK_TIMEOUT  (P_LT),
        .SETTLE_CYCLES (P_SET),
        .MAX_RETRIES   (P_MR),
        .CNT_W         (P_CW)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .pll_lock  (pll_lock),
        .retry_req (retry_req),
        .pll_rst   (pll_rst),
        .rst_out   (rst_out),
        .locked    (locked),
        .failed    (failed),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk_in = ~clk_in;

    // ------------------------------------------------------------------
    // Reference model: an attempt timeline driven by elapsed-time counts
    // ------------------------------------------------------------------
    typedef enum {M_PULSE, M_AWAIT, M_QUALIFY, M_UP, M_DEAD} mode_t;
    mode_t m_mode;
    int    m_t, m_good, m_retries, m_losses;
    bit    m_h0, m_h1;

    function automatic void model_reset();
        m_mode = M_PULSE; m_t = 0; m_good = 0; m_retries = 0; m_losses = 0;
        m_h0 = 1'b0; m_h1 = 1'b0;
    endfunction

    function automatic void model_step();
        bit ls;
        ls = m_h1;            // lock as seen two edges after sampling
        m_h1 = m_h0;
        m_h0 = pll_lock;
        if (retry_req) begin
            m_mode = M_PULSE; m_t = 0; m_retries = 0;
        end else begin
            case (m_mode)
                M_PULSE: begin
                    m_t++;
                    if (m_t == P_RST) begin m_mode = M_AWAIT; m_t = 0; end
                end
                M_AWAIT: begin
                    if (ls) begin
                        m_mode = M_QUALIFY; m_good = 1;
                    end else begin
                        m_t++;
                        if (m_t == P_LT) begin
                            m_retries++; m_t = 0;
                            m_mode = (m_retries == P_MR) ? M_DEAD : M_PULSE;
                        end
                    end
                end
                M_QUALIFY: begin
                    if (!ls) begin
                        m_mode = M_AWAIT; m_t = 0;
                    end else begin
                        m_good++;
                        if (m_good >= P_SET) begin m_mode = M_UP; m_retries = 0; end
                    end
                end
                M_UP: begin
                    if (!ls) begin
                        m_mode = M_PULSE; m_t = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = '0;
        v[19]    = (m_mode == M_PULSE) || (m_mode == M_DEAD);
        v[18]    = (m_mode != M_UP);
        v[17]    = (m_mode == M_UP);
        v[16]    = (m_mode == M_DEAD);
        v[15:8]  = 8'(m_retries);
        v[7:0]   = 8'(m_losses);
        return v;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {12'd0, pll_rst, rst_out, locked, failed, retry_cnt, loss_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge and compare 1 time unit later
    task automatic cyc();
        @(posedge clk_in);
        if (rst_n_in) model_step();
        else          model_reset();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic wait_locked(input string name);
        int n;
        n = 0;
        while (!locked && n < 60) begin
            cyc();
            n++;
        end
        check(name, {31'd0, locked}, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed table: hold inputs for n cycles, then compare outputs
    // ------------------------------------------------------------------
    typedef struct {
        int n; int lock; int req;
        int prst; int rout; int lk; int fl; int retry; int loss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, int lock, int req, int prst, int rout,
                                int lk, int fl, int retry, int loss);
        vec_t v;
        v.n = n; v.lock = lock; v.req = req; v.prst = prst; v.rout = rout;
        v.lk = lk; v.fl = fl; v.retry = retry; v.loss = loss;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_v;
        int          loops;

        // Nominal lock, lock loss, three timed-out attempts, then recovery
        tbl.push_back(mk( 3, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk( 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk( 4, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk( 9, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk( 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk( 2, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk( 1, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(23, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk( 1, 0, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(24, 0, 0, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(23, 0, 0, 0, 1, 0, 0, 2, 1));
        tbl.push_back(mk( 1, 0, 0, 1, 1, 0, 1, 3, 1));
        tbl.push_back(mk(10, 0, 0, 1, 1, 0, 1, 3, 1));
        tbl.push_back(mk( 1, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk( 4, 0, 0, 0, 1, 0, 0, 0, 1));

        model_reset();
        repeat (3) cyc();
        check("reset_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("reset_rst_out", {31'd0, rst_out}, 32'd1);
        check("reset_flags",   {30'd0, locked, failed}, 32'd0);
        check("reset_counts",  {16'd0, retry_cnt, loss_cnt}, 32'd0);
        rst_n_in = 1'b1;

        foreach (tbl[i]) begin
            pll_lock  = tbl[i].lock[0];
            retry_req = tbl[i].req[0];
            repeat (tbl[i].n) cyc();
            exp_v = {12'd0, tbl[i].prst[0], tbl[i].rout[0], tbl[i].lk[0], tbl[i].fl[0],
                     8'(tbl[i].retry), 8'(tbl[i].loss)};
            check($sformatf("table_row%0d", i), dut_vec(), exp_v);
        end
        retry_req = 1'b0;

        // Glitchy lock during settle: the settle window must restart
        pll_lock = 1'b1;
        repeat (3) cyc();
        pll_lock = 1'b0;
        repeat (2) cyc();
        pll_lock = 1'b1;
        repeat (9) cyc();
        check("glitch_not_early", {31'd0, locked}, 32'd0);
        check("glitch_retry",     {24'd0, retry_cnt}, 32'd0);
        cyc();
        check("glitch_run_at_10", {31'd0, locked}, 32'd1);

        // Lock loss coinciding with retry_req is not counted
        pll_lock = 1'b0;
        repeat (2) cyc();
        retry_req = 1'b1;
        cyc();
        retry_req = 1'b0;
        check("loss_req_rst_out", {31'd0, rst_out}, 32'd1);
        check("loss_req_count",   {24'd0, loss_cnt}, 32'd1);
        pll_lock = 1'b1;
        wait_locked("loss_req_relock");

        // Repeated lock loss: rst_out rises 3 cycles after each fall
        loops = 300;
        for (int i = 0; i < loops; i++) begin
            pll_lock = 1'b0;
            repeat (2) cyc();
            check("loss_rst_out_hold", {31'd0, rst_out}, 32'd0);
            cyc();
            check("loss_rst_out_rise", {31'd0, rst_out}, 32'd1);
            pll_lock = 1'b1;
            wait_locked("loss_relock");
        end
        check("loss_saturated", {24'd0, loss_cnt}, 32'd255);

        // Asynchronous reset in the middle of SETTLE
        retry_req = 1'b1;
        cyc();
        retry_req = 1'b0;
        repeat (7) cyc();
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check("async_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("async_all",     dut_vec(), model_vec());
        repeat (2) cyc();
        rst_n_in = 1'b1;
        repeat (3) cyc();
        check("restart_pll_rst_hi", {31'd0, pll_rst}, 32'd1);
        cyc();
        check("restart_pll_rst_lo", {31'd0, pll_rst}, 32'd0);
        wait_locked("restart_relock");

        // Randomized lock segments with occasional retry requests
        loops = 0;
        while (loops < 3000) begin
            int len;
            pll_lock = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 70));
            for (int k = 0; k < len; k++) begin
                retry_req = ($urandom_range(0, 99) == 0);
                cyc();
                loops++;
            end
        end
        retry_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
